// File: rtl/counter_arbiter.sv
// Round-robin arbiter with a bounded grant length: one owner at a time, handoff
// on drop, release or slice expiry when someone else is waiting.
package counter_arbiter_pkg;
  typedef struct packed {
    logic clk;
    logic rst;
  } data_control_t;
endpackage

module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SLICE = 8,
  parameter int unsigned IW    = $clog2(N),
  parameter int unsigned CW    = $clog2(SLICE)
) (
  input  data_control_t ctrl,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  release_pulse,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] owner,
  output logic          busy,
  output logic [CW-1:0] slice
);

  typedef enum logic {IDLE, HELD} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] slice_q, slice_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [IW-1:0] owner_next_c;
  logic [IW-1:0] search_start_c;
  logic [IW-1:0] pick_c;
  logic          found_c;
  logic          others_pend_c;
  logic          slice_last_c;
  logic          end_c;
  int unsigned   idx;

  assign owner_next_c = (owner_q == IW'(N-1)) ? '0 : owner_q + IW'(1);

  // Next-owner search; while HELD it starts past the owner and never picks it.
  always_comb begin
    search_start_c = (state_q == HELD) ? owner_next_c : ptr_q;
    found_c        = 1'b0;
    pick_c         = '0;
    idx            = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(search_start_c) + i;
      if (idx >= N) idx = idx - N;
      if (!found_c && req[IW'(idx)] && !(state_q == HELD && IW'(idx) == owner_q)) begin
        found_c = 1'b1;
        pick_c  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    slice_d = slice_q;
    ptr_d   = ptr_q;

    others_pend_c = |(req & ~grant_q);
    slice_last_c  = (slice_q == CW'(SLICE-1));
    end_c         = !req[owner_q] || release_pulse[owner_q] ||
                    (slice_last_c && others_pend_c);

    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = HELD;
          grant_d = N'(1) << pick_c;
          owner_d = pick_c;
          busy_d  = 1'b1;
          slice_d = '0;
        end
      end
      HELD: begin
        if (end_c) begin
          ptr_d   = owner_next_c;
          slice_d = '0;
          if (found_c) begin
            grant_d = N'(1) << pick_c;
            owner_d = pick_c;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
            busy_d  = 1'b0;
          end
        end else begin
          // Sole requester past the last slice cycle simply starts a new slice.
          slice_d = slice_last_c ? '0 : slice_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge ctrl.clk) begin
    if (ctrl.rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      slice_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      slice_q <= slice_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign slice = slice_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter (N=4, SLICE=4): reference-model scoreboard plus
// directed checks of the documented scenarios and a random soak.
module tb_counter_arbiter;
  import counter_arbiter_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned SLICE = 4;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic [1:0] slice;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  rel;
  logic [N-1:0]  grant;
  logic [1:0]    owner;
  logic          busy;
  logic [1:0]    slice;
  data_control_t ctrl;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];

  // Reference model state: m_owner < 0 means idle.
  int m_owner = -1;
  int m_slice = 0;
  int m_ptr   = 0;

  assign ctrl = '{clk: clk, rst: rst};

  counter_arbiter #(.N(N), .SLICE(SLICE)) dut (
    .ctrl          (ctrl),
    .req           (req),
    .release_pulse (rel),
    .grant         (grant),
    .owner         (owner),
    .busy          (busy),
    .slice         (slice)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] rl, input logic rs);
    int nxt;
    bit endc;
    if (rs) begin
      m_owner = -1; m_slice = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_slice = 0;
        end
      end
    end else begin
      endc = !r[m_owner] || rl[m_owner] ||
             (m_slice == SLICE - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000);
      if (endc) begin
        nxt = -1;
        for (int k = 1; k < 4; k++)
          if (nxt < 0 && r[(m_owner + k) % 4]) nxt = (m_owner + k) % 4;
        m_ptr   = (m_owner + 1) % 4;
        m_owner = nxt;
        m_slice = 0;
      end else begin
        m_slice = (m_slice + 1) % SLICE;
      end
    end
  endtask

  // One clock: drive on the falling edge, predict, then compare after the rise.
  task automatic cyc(input logic [3:0] r, input logic [3:0] rl, input logic rs);
    exp_t e;
    @(negedge clk);
    req = r; rel = rl; rst = rs;
    model_step(r, rl, rs);
    e.grant = (m_owner < 0) ? 4'b0000 : 4'(4'b0001 << m_owner);
    e.owner = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e.busy  = (m_owner >= 0);
    e.slice = 2'(m_slice);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("sb_grant", 32'(grant), 32'(e.grant));
      check("sb_owner", 32'(owner), 32'(e.owner));
      check("sb_busy",  32'(busy),  32'(e.busy));
      check("sb_slice", 32'(slice), 32'(e.slice));
    end
  endtask

  initial begin
    req = '0; rel = '0; rst = 1'b1;

    // Reset, then two requesters sharing with a 4-cycle slice.
    cyc(4'b0000, 4'b0000, 1'b1);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_slice", 32'(slice), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0101, 4'b0000, 1'b0);
      check("s29_grant", 32'(grant), 32'h1);
      check("s29_slice", 32'(slice), 32'(i));
    end
    cyc(4'b0101, 4'b0000, 1'b0);
    check("s29_hand_grant", 32'(grant), 32'h4);
    check("s29_hand_slice", 32'(slice), 32'h0);

    // Lone requester keeps the grant across slice wraps.
    cyc(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0010, 4'b0000, 1'b0);
      check("s30_grant", 32'(grant), 32'h2);
      check("s30_slice", 32'(slice), 32'(i % 4));
      check("s30_busy",  32'(busy),  32'h1);
    end

    // Early release hands off forward, then wraps back to owner 1.
    cyc(4'b1010, 4'b0010, 1'b0);
    check("s31_grant3", 32'(grant), 32'h8);
    check("s31_slice3", 32'(slice), 32'h0);
    cyc(4'b1010, 4'b0000, 1'b0);
    cyc(4'b1010, 4'b1000, 1'b0);
    check("s31_grant1", 32'(grant), 32'h2);

    // Owner 2 drops, pointer moves to 3, next search wraps to 0.
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b0);
    check("s32_own2", 32'(owner), 32'h2);
    cyc(4'b0000, 4'b0000, 1'b0);
    check("s32_idle_grant", 32'(grant), 32'h0);
    check("s32_idle_busy",  32'(busy),  32'h0);
    check("s32_idle_owner", 32'(owner), 32'h0);
    cyc(4'b0111, 4'b0000, 1'b0);
    check("s32_wrap_grant", 32'(grant), 32'h1);

    // Release by sole requester forces one idle cycle before regrant.
    cyc(4'b0001, 4'b0001, 1'b0);
    check("s33_idle", 32'(grant), 32'h0);
    cyc(4'b0001, 4'b0000, 1'b0);
    check("s33_regrant", 32'(grant), 32'h1);

    // Reset mid-grant clears everything without advancing the pointer.
    cyc(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'b1000, 4'b0000, 1'b0);
    check("s34_pre_slice", 32'(slice), 32'h2);
    cyc(4'b1000, 4'b0000, 1'b1);
    check("s34_rst_all", 32'({grant, owner, busy, slice}), 32'h0);
    cyc(4'b1001, 4'b0000, 1'b0);
    check("s34_grant0", 32'(grant), 32'h1);

    // Random soak against the reference model.
    for (int i = 0; i < 300; i++) begin
      cyc(4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
          ($urandom_range(0, 40) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: Counter_arbiter

Parameters
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..16).
REQ-002 The block SHALL have parameter SLICE, default 8, meaning the maximum grant length in cycles (>=2).
REQ-003 The block SHALL have parameter IW, default Util_Math_log2(N), meaning the width of the owner index.
REQ-004 The block SHALL have parameter CW, default Util_Math_log2(SLICE), meaning the width of the slice counter.

Interface
REQ-005 The block SHALL have port ctrl, input, Data_Control_T: the control bundle; its clock field is the single clock, rising edge.
REQ-006 The ctrl reset field SHALL be the reset: synchronous, active-high, sampled on the ctrl clock edge.
REQ-007 The block SHALL have port req, input, N bits: level request per requester.
REQ-008 The block SHALL have port release, input, N bits: a one-cycle pulse in which the owner gives up its grant early.
REQ-009 The block SHALL have port grant, output, N bits: one-hot grant, or all-zero when no requester owns the resource.
REQ-010 The block SHALL have port owner, output, IW bits: index of the granted requester; 0 when idle.
REQ-011 The block SHALL have port busy, output, 1 bit: high exactly when grant is non-zero.
REQ-012 The block SHALL have port slice, output, CW bits: cycles already spent in the current grant, 0-based.

Function
REQ-013 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-014 The block SHALL have two states. IDLE means grant is zero. HELD means exactly one grant bit is set.
REQ-015 IDLE with req != 0: at the next edge the block SHALL go to HELD, grant the first requesting index searching upward from ptr (wrapping), and set slice to 0.
REQ-016 ptr SHALL be an internal IW-bit round-robin pointer. It SHALL be set to (owner+1) mod N every time a grant ends.
REQ-017 HELD, each cycle with no end condition: slice SHALL increment by 1.
REQ-018 End conditions, evaluated on owner bits only:
  (a) req[owner] low;
  (b) release[owner] high;
  (c) slice == SLICE-1 and at least one other req bit high.
REQ-019 On an end condition, at that same edge, the block SHALL grant the next requester. The search SHALL start at (owner+1) mod N, SHALL exclude the current owner, and SHALL set slice to 0. The handoff SHALL have no bubble cycle.
REQ-020 If an end condition occurs and no other requester is pending, the block SHALL go to IDLE at that edge. The current owner SHALL NOT be re-granted in the same edge, even if its req is still high.
REQ-021 slice == SLICE-1 with no other requester pending and req[owner] high: the owner SHALL keep the grant and slice SHALL wrap to 0. When SLICE is a power of two, this wrap is the natural rollover.
REQ-022 release bits and req bits of non-owners SHALL be ignored while HELD, except that req bits take part in condition (c) and in the next-owner search.
REQ-023 If several end conditions hold in the same cycle, the outcome SHALL be identical to a single end condition.
REQ-024 The owner and busy outputs SHALL always be consistent with grant in the same cycle.

Reset
REQ-025 Reset SHALL have priority over every other input.
REQ-026 On reset the block SHALL set grant=0, owner=0, busy=0, slice=0, ptr=0, and state=IDLE.
REQ-027 Reset asserted while HELD SHALL drop grant at that edge. No end-of-grant side effect, such as a ptr update to owner+1, SHALL occur.
REQ-028 In the first cycle after reset deasserts, the block SHALL arbitrate from ptr=0.

Verification
All scenarios use N=4, SLICE=4.
REQ-029 Reset, then req=0101 held: grant=0001 one cycle after reset deasserts. slice counts 0,1,2,3. Next edge: grant=0100, slice=0.
REQ-030 req=0010 only, held for 10 cycles: grant stays 0010 throughout. slice runs 0,1,2,3,0,1,2,3,0,1. busy stays 1.
REQ-031 Owner=1, release=0010 pulse at slice=1 with req=1010: next edge grant=1000, slice=0. A later release from owner 3 with req=1010 regrants owner 1 (search wraps from 0).
REQ-032 Owner=2, req drops to 0000: next edge grant=0000, busy=0, owner=0. Then req=0111: grant=1000 is never given; grant=0001 (ptr=3 wraps to 0).
REQ-033 Owner=0, release=0001 with req=0001 still high: next edge IDLE with grant=0000. Following edge grant=0001 again.
REQ-034 Reset asserted while owner=3 and slice=2: next edge all outputs are 0. With req=1001 after reset deasserts, grant=0001.
